// File: rtl/clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : clock_set_ctrl (with helper clock_set_ctrl_key)           |
// | Purpose  : Push-button front end for a clock time-keeper. Debounces  |
// |            three active-low keys, steps the set-mode FSM and issues  |
// |            one up/down adjust request per accepted key press.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+

// Per-key conditioning: synchronizer chain, debouncer, and press pulse.
module clock_set_ctrl_key #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1 before the level is accepted.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   stable;
  logic [CNT_W-1:0]       cnt;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      // Single-flop synchronizer; idles high like a released key.
      always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= key_raw;
      end
    end else begin : g_sync_chain
      // Multi-flop synchronizer chain; idles high like a released key.
      always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
      end
    end
  endgenerate

  assign sample = sync_q[SYNC_STAGES-1];

  // Debouncer: accept a new level only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sample == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sample;
        cnt    <= '0;
        // A change away from a high stable level is a 1->0 transition, i.e. a press.
        press  <= stable;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// Top level: three conditioned keys driving the mode FSM and adjust request.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyMode,
  input  logic       keyUp,
  input  logic       keyDown,
  input  logic       oneSecTick,
  output logic       set,
  output logic [1:0] sethms,
  output logic [1:0] upDown,
  output logic       on,
  output logic [3:0] modeLeds
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_SET_H = 2'd1;
  localparam logic [1:0] S_SET_M = 2'd2;
  localparam logic [1:0] S_SET_S = 2'd3;

  localparam logic [1:0] UD_IDLE = 2'b00;
  localparam logic [1:0] UD_UP   = 2'b01;
  localparam logic [1:0] UD_DOWN = 2'b10;

  // Index order of the conditioned keys: [2]=mode, [1]=up, [0]=down.
  logic [2:0] keys_raw;
  logic [2:0] keys_press;

  assign keys_raw = {keyMode, keyUp, keyDown};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_key
      clock_set_ctrl_key #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
      ) u_key (
        .clk     (clk),
        .reset   (reset),
        .key_raw (keys_raw[i]),
        .press   (keys_press[i])
      );
    end
  endgenerate

  logic mode_press;
  logic up_press;
  logic down_press;

  assign mode_press = keys_press[2];
  assign up_press   = keys_press[1];
  assign down_press = keys_press[0];

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [1:0] up_down;
  logic [1:0] up_down_nx;

  // Next-state: a live request locks out every key until a tick retires it.
  always_comb begin
    state_nx   = state;
    up_down_nx = up_down;
    if (up_down != UD_IDLE) begin
      // up_down here is the value at the start of the cycle, so a tick
      // coinciding with the loading press cannot retire the new request.
      if (oneSecTick) up_down_nx = UD_IDLE;
    end else if (mode_press) begin
      // Mode wins over a coincident adjust press; the adjust is dropped.
      case (state)
        S_RUN:   state_nx = S_SET_H;
        S_SET_H: state_nx = S_SET_M;
        S_SET_M: state_nx = S_SET_S;
        default: state_nx = S_RUN;
      endcase
    end else if ((state != S_RUN) && (up_press ^ down_press)) begin
      up_down_nx = up_press ? UD_UP : UD_DOWN;
    end
  end

  logic       set_q;
  logic       on_q;
  logic [1:0] sethms_q;
  logic [3:0] leds_q;

  // State, request and decoded outputs all registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      up_down  <= UD_IDLE;
      set_q    <= 1'b0;
      on_q     <= 1'b1;
      sethms_q <= 2'b11;
      leds_q   <= 4'b0001;
    end else begin
      state   <= state_nx;
      up_down <= up_down_nx;
      case (state_nx)
        S_SET_H: begin
          set_q    <= 1'b1;
          on_q     <= 1'b0;
          sethms_q <= 2'b00;
          leds_q   <= 4'b0010;
        end
        S_SET_M: begin
          set_q    <= 1'b1;
          on_q     <= 1'b0;
          sethms_q <= 2'b01;
          leds_q   <= 4'b0100;
        end
        S_SET_S: begin
          set_q    <= 1'b1;
          on_q     <= 1'b0;
          sethms_q <= 2'b10;
          leds_q   <= 4'b1000;
        end
        default: begin
          set_q    <= 1'b0;
          on_q     <= 1'b1;
          sethms_q <= 2'b11;
          leds_q   <= 4'b0001;
        end
      endcase
    end
  end

  assign set      = set_q;
  assign on       = on_q;
  assign sethms   = sethms_q;
  assign upDown   = up_down;
  assign modeLeds = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_clock_set_ctrl                                         |
// | Purpose  : Directed self-checking bench for clock_set_ctrl with      |
// |            DEBOUNCE_CYCLES=4, SYNC_STAGES=2.                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_clock_set_ctrl;

  localparam int DEB  = 4;
  localparam int SYNC = 2;

  // Expected output word: {set, on, sethms[1:0], upDown[1:0], modeLeds[3:0]}
  localparam logic [9:0] E_RUN   = 10'b0_1_11_00_0001;
  localparam logic [9:0] E_SET_H = 10'b1_0_00_00_0010;
  localparam logic [9:0] E_SET_M = 10'b1_0_01_00_0100;
  localparam logic [9:0] E_SET_S = 10'b1_0_10_00_1000;
  localparam logic [9:0] UD_UP   = 10'b0_0_00_01_0000;
  localparam logic [9:0] UD_DN   = 10'b0_0_00_10_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       keyMode;
  logic       keyUp;
  logic       keyDown;
  logic       oneSecTick;
  logic       set;
  logic       on;
  logic [1:0] sethms;
  logic [1:0] upDown;
  logic [3:0] modeLeds;
  logic [9:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keyMode    (keyMode),
    .keyUp      (keyUp),
    .keyDown    (keyDown),
    .oneSecTick (oneSecTick),
    .set        (set),
    .sethms     (sethms),
    .upDown     (upDown),
    .on         (on),
    .modeLeds   (modeLeds)
  );

  assign obs = {set, on, sethms, upDown, modeLeds};

  typedef struct {
    string      name;
    bit         rst;
    bit [2:0]   keys;   // [2]=mode [1]=up [0]=down, 1 = pressed
    int         hold;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input string n, input bit r, input bit [2:0] k,
                              input int h, input logic [9:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.keys = k; v.hold = h; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {set,on,sethms,upDown,leds}=%b expected %b", name, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return at the next falling edge.
  task automatic cyc(input logic r, input logic m, input logic u, input logic d, input logic t);
    reset = r; keyMode = m; keyUp = u; keyDown = d; oneSecTick = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // Press (active-low) for 8 cycles, then release long enough to settle.
  task automatic press_key(input bit m, input bit u, input bit d);
    repeat (8) cyc(1'b0, !m, !u, !d, 1'b0);
    idle(10);
  endtask

  initial begin
    reset = 1'b1; keyMode = 1'b1; keyUp = 1'b1; keyDown = 1'b1; oneSecTick = 1'b0;

    vecs[0]  = mk("reset",          1'b1, 3'b000,  2, E_RUN);
    vecs[1]  = mk("run_up_ignored", 1'b0, 3'b010, 10, E_RUN);
    vecs[2]  = mk("run_dn_ignored", 1'b0, 3'b001, 10, E_RUN);
    vecs[3]  = mk("run_glitch",     1'b0, 3'b100,  3, E_RUN);
    vecs[4]  = mk("mode_to_set_h",  1'b0, 3'b100, 10, E_SET_H);
    vecs[5]  = mk("up_dn_together", 1'b0, 3'b011, 10, E_SET_H);
    vecs[6]  = mk("mode_to_set_m",  1'b0, 3'b100, 10, E_SET_M);
    vecs[7]  = mk("mode_to_set_s",  1'b0, 3'b100, 10, E_SET_S);
    vecs[8]  = mk("mode_to_run",    1'b0, 3'b100, 10, E_RUN);
    vecs[9]  = mk("mode_to_set_h2", 1'b0, 3'b100, 10, E_SET_H);
    vecs[10] = mk("set_h_glitch",   1'b0, 3'b100,  3, E_SET_H);
    vecs[11] = mk("mode_to_set_m2", 1'b0, 3'b100, 10, E_SET_M);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) begin
        repeat (vecs[i].hold) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      end else begin
        repeat (vecs[i].hold) cyc(1'b0, !vecs[i].keys[2], !vecs[i].keys[1], !vecs[i].keys[0], 1'b0);
        idle(10);
      end
      check(vecs[i].name, vecs[i].exp);
    end

    // keyUp press in SET_M: request from press+1, tick five cycles after the press
    for (int k = 1; k <= 14; k++) begin
      cyc(1'b0, 1'b1, !(k <= 8), 1'b1, (k == 11));
      check($sformatf("up_tick_k%0d", k), ((k >= 7) && (k <= 10)) ? (E_SET_M | UD_UP) : E_SET_M);
    end
    idle(4);

    // Tick coinciding with the loading press must not retire the request
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 1'b1, 1'b1, !(k <= 8), (k == 7));
      if (k >= 6)
        check($sformatf("dn_same_tick_k%0d", k), (k >= 7) ? (E_SET_M | UD_DN) : E_SET_M);
    end
    idle(8);
    check("dn_held_no_tick", E_SET_M | UD_DN);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("dn_cleared", E_SET_M);

    // Further adjust presses during a live request are ignored and not queued
    press_key(1'b0, 1'b1, 1'b0);
    check("live_up", E_SET_M | UD_UP);
    press_key(1'b0, 1'b0, 1'b1);
    check("live_dn_ignored", E_SET_M | UD_UP);
    press_key(1'b0, 1'b1, 1'b0);
    check("live_up_ignored", E_SET_M | UD_UP);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("live_cleared", E_SET_M);
    idle(10);
    check("nothing_queued", E_SET_M);

    // Mode press under a live request is dropped
    press_key(1'b1, 1'b0, 1'b0);
    check("to_set_s", E_SET_S);
    press_key(1'b0, 1'b0, 1'b1);
    check("set_s_dn", E_SET_S | UD_DN);
    press_key(1'b1, 1'b0, 1'b0);
    check("mode_dropped_live", E_SET_S | UD_DN);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("set_s_cleared", E_SET_S);
    idle(10);
    check("mode_not_queued", E_SET_S);

    // Simultaneous mode + adjust: mode only
    press_key(1'b1, 1'b1, 1'b0);
    check("mode_up_together", E_RUN);
    press_key(1'b1, 1'b0, 1'b1);
    check("mode_dn_together", E_SET_H);

    // Reset during a live request
    press_key(1'b0, 1'b0, 1'b1);
    check("set_h_dn", E_SET_H | UD_DN);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("reset_mid_request", E_RUN);

    // keyMode held through a reset that interrupts its debounce; held key must not repeat
    for (int k = 1; k <= 22; k++) begin
      cyc((k == 4) || (k == 5), 1'b0, 1'b1, 1'b1, 1'b0);
      if (k >= 6)
        check($sformatf("held_thru_reset_k%0d", k), (k >= 12) ? E_SET_H : E_RUN);
    end
    idle(12);
    check("after_release", E_SET_H);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
